// File: rtl/alu_operand_collector.sv
// Merges A/B operand beats into one registered ALU operation,
// issuing a partial operation when the partner beat times out.
module alu_operand_collector #(
  parameter int OP_WIDTH    = 8,
  parameter int CMD_WIDTH   = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 CE,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [1:0]           op_sel,
  input  logic                 op_mode,
  input  logic [CMD_WIDTH-1:0] op_cmd,
  input  logic [OP_WIDTH-1:0]  op_a,
  input  logic [OP_WIDTH-1:0]  op_b,
  input  logic                 op_cin,
  output logic [1:0]           INP_VALID,
  output logic                 MODE,
  output logic [CMD_WIDTH-1:0] CMD,
  output logic [OP_WIDTH-1:0]  OPA,
  output logic [OP_WIDTH-1:0]  OPB,
  output logic                 CIN,
  output logic                 issue,
  output logic                 timeout_err,
  output logic                 drop
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_A,
    S_WAIT_B,
    S_ISSUE
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [OP_WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic                 mode_q, mode_d, cin_q, cin_d;
  logic [CMD_WIDTH-1:0] cmd_q, cmd_d;
  logic [1:0]           iv_q, iv_d;
  logic [OP_WIDTH-1:0]  opa_q, opa_d, opb_q, opb_d;
  logic                 omode_q, omode_d, ocin_q, ocin_d;
  logic [CMD_WIDTH-1:0] ocmd_q, ocmd_d;
  logic                 issue_q, issue_d;
  logic                 to_q, to_d;
  logic                 drop_q, drop_d;

  logic       acc;
  logic       go;
  logic       timed;
  logic [1:0] mask;

  assign op_ready = CE && !RST && (state_q != S_ISSUE);
  assign acc      = op_valid && op_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    cmd_d   = cmd_q;
    cin_d   = cin_q;
    iv_d    = iv_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    omode_d = omode_q;
    ocmd_d  = ocmd_q;
    ocin_d  = ocin_q;
    issue_d = 1'b0;
    to_d    = 1'b0;
    drop_d  = 1'b0;
    go      = 1'b0;
    timed   = 1'b0;
    mask    = 2'b00;
    if (CE) begin
      unique case (state_q)
        S_IDLE: begin
          if (acc) begin
            unique case (op_sel)
              2'b11: begin
                a_d    = op_a;
                b_d    = op_b;
                mode_d = op_mode;
                cmd_d  = op_cmd;
                cin_d  = op_cin;
                go     = 1'b1;
                mask   = 2'b11;
              end
              2'b01: begin
                a_d     = op_a;
                mode_d  = op_mode;
                cmd_d   = op_cmd;
                cin_d   = op_cin;
                cnt_d   = '0;
                state_d = S_WAIT_B;
              end
              2'b10: begin
                b_d     = op_b;
                mode_d  = op_mode;
                cmd_d   = op_cmd;
                cin_d   = op_cin;
                cnt_d   = '0;
                state_d = S_WAIT_A;
              end
              default: drop_d = 1'b1;
            endcase
          end
        end
        S_WAIT_B: begin
          if (acc && op_sel[1]) begin
            b_d  = op_b;
            go   = 1'b1;
            mask = 2'b11;
          end else begin
            if (acc && op_sel == 2'b01) begin
              a_d    = op_a;
              mode_d = op_mode;
              cmd_d  = op_cmd;
              cin_d  = op_cin;
            end
            drop_d = acc && (op_sel == 2'b00);
            if (cnt_q == LAST) begin
              go    = 1'b1;
              timed = 1'b1;
              mask  = 2'b01;
            end else if (acc && op_sel == 2'b01) begin
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        S_WAIT_A: begin
          if (acc && op_sel[0]) begin
            a_d  = op_a;
            go   = 1'b1;
            mask = 2'b11;
          end else begin
            if (acc && op_sel == 2'b10) begin
              b_d    = op_b;
              mode_d = op_mode;
              cmd_d  = op_cmd;
              cin_d  = op_cin;
            end
            drop_d = acc && (op_sel == 2'b00);
            if (cnt_q == LAST) begin
              go    = 1'b1;
              timed = 1'b1;
              mask  = 2'b10;
            end else if (acc && op_sel == 2'b10) begin
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
      // Uncollected operand pins keep their last issued value
      if (go) begin
        state_d = S_ISSUE;
        issue_d = 1'b1;
        to_d    = timed;
        iv_d    = mask;
        if (mask[0]) opa_d = a_d;
        if (mask[1]) opb_d = b_d;
        omode_d = mode_d;
        ocmd_d  = cmd_d;
        ocin_d  = cin_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      cmd_q   <= '0;
      cin_q   <= 1'b0;
      iv_q    <= 2'b00;
      opa_q   <= '0;
      opb_q   <= '0;
      omode_q <= 1'b0;
      ocmd_q  <= '0;
      ocin_q  <= 1'b0;
      issue_q <= 1'b0;
      to_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      cmd_q   <= cmd_d;
      cin_q   <= cin_d;
      iv_q    <= iv_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      omode_q <= omode_d;
      ocmd_q  <= ocmd_d;
      ocin_q  <= ocin_d;
      issue_q <= issue_d;
      to_q    <= to_d;
      drop_q  <= drop_d;
    end
  end

  assign INP_VALID   = iv_q;
  assign MODE        = omode_q;
  assign CMD         = ocmd_q;
  assign OPA         = opa_q;
  assign OPB         = opb_q;
  assign CIN         = ocin_q;
  assign issue       = issue_q;
  assign timeout_err = to_q;
  assign drop        = drop_q;

endmodule

// File: doc/alu_operand_collector.md
Name: alu_operand_collector

Overview:
- Stage directly upstream of the ALU. It sits between the operand source and the ALU's input pins.
- Operands A and B can arrive in separate beats. The block merges them into one registered ALU operation and drives INP_VALID, MODE, CMD, OPA, OPB and CIN.
- If the partner operand does not arrive within TIMEOUT_CYC cycles, it issues a partial operation and flags a timeout. This matches the ALU's 16-cycle INP_VALID rule.

Parameters:
- OP_WIDTH, 8: operand width.
- CMD_WIDTH, 4: command width.
- TIMEOUT_CYC, 16: maximum number of CE cycles spent waiting for the second operand.

Ports:
- clk  in  1  clock
- RST  in  1  synchronous, active-high reset
- CE  in  1  clock enable; when low, all state freezes
- op_valid  in  1  source beat valid
- op_ready  out  1  collector can accept a beat (combinational)
- op_sel  in  2  beat content: 01 = A only, 10 = B only, 11 = both, 00 = empty
- op_mode  in  1  ALU mode (1 = arithmetic)
- op_cmd  in  CMD_WIDTH  ALU command
- op_a  in  OP_WIDTH  operand A
- op_b  in  OP_WIDTH  operand B
- op_cin  in  1  carry-in
- INP_VALID  out  2  operand-valid mask to the ALU (registered)
- MODE  out  1  to ALU (registered)
- CMD  out  CMD_WIDTH  to ALU (registered)
- OPA  out  OP_WIDTH  to ALU (registered)
- OPB  out  OP_WIDTH  to ALU (registered)
- CIN  out  1  to ALU (registered)
- issue  out  1  one-cycle strobe marking a new operation on the ALU pins
- timeout_err  out  1  one-cycle pulse, coincident with issue, when the issued operation is partial
- drop  out  1  one-cycle pulse when an op_sel=00 beat is discarded

Behaviour:
- Reset (RST high at a posedge) forces:
  - state IDLE, counter 0
  - all ALU-side outputs, issue, timeout_err and drop to 0
  - any partially collected operands discarded
  - RST takes priority over CE and over all beats.
- Beat acceptance:
  - A beat is accepted when op_valid && op_ready at a posedge.
  - op_ready = CE && !RST && state != ISSUE.
  - No beat is accepted while CE is low.
- CE low: FSM state, counter, internal latches and outputs all hold. Strobes issue, timeout_err and drop are forced to 0.
- FSM states and transitions:
  - IDLE:
    - sel 11: latch all fields, go to ISSUE.
    - sel 01: latch A, mode, cmd and cin; clear counter; go to WAIT_B.
    - sel 10: latch B, mode, cmd and cin; clear counter; go to WAIT_A.
    - sel 00: discard the beat, pulse drop, stay in IDLE.
  - WAIT_B:
    - sel 10 or 11: take only op_b; mask becomes 11; go to ISSUE.
    - sel 01: replace A, mode, cmd and cin; clear counter (resync).
    - sel 00: pulse drop.
  - WAIT_A: symmetric to WAIT_B, with A and B swapped.
  - Timeout: counter increments on every CE cycle spent in a WAIT state. If the counter equals TIMEOUT_CYC-1 and no completing beat is accepted in that cycle, go to ISSUE with the partial mask (01 or 10) and set timeout_err.
    - A completing beat in that same cycle wins and gives a normal issue.
    - The maximum residence in a WAIT state is therefore TIMEOUT_CYC cycles.
  - ISSUE:
    - Lasts exactly one CE cycle, then returns to IDLE.
    - A beat offered during ISSUE is stalled, because op_ready is 0.
- Output timing:
  - ALU pins are loaded on the edge that enters ISSUE, and issue goes high for that cycle.
  - Latency is 1 cycle: a sel=11 beat accepted at edge N appears on the ALU pins from edge N until the next issue or reset.
  - Between issues, the ALU pins hold the last issued values; INP_VALID is never driven 00 except after reset.
  - Fields not collected in a partial issue keep their previous register values.
- No arithmetic is performed. Widths pass straight through with no truncation.

Test Plan:
- Reset, then a beat with sel=11, A=8'h3C, B=8'h05, mode=1, cmd=0, cin=0 -> next cycle: INP_VALID=11, OPA=3C, OPB=05, issue=1 for 1 cycle. op_ready=0 in that cycle.
- Beat sel=01 with A=8'h10, then after 5 cycles a beat sel=10 with B=8'h20 -> one issue with INP_VALID=11, OPA=10, OPB=20, timeout_err=0.
- Beat sel=10 with B=8'hAA, no further beats -> exactly 16 cycles later: issue=1, timeout_err=1, INP_VALID=10, OPB=AA.
- Completing beat arrives in the 16th wait cycle -> normal issue with INP_VALID=11 and timeout_err=0.
- Beat sel=01, then CE held low for 20 cycles, then CE high -> no timeout during the CE-low window; the timeout fires 16 CE-high cycles after the wait began, counting only CE-high cycles.
- RST asserted in WAIT_B, followed by a beat sel=10 -> no issue occurs; all outputs are 0; the beat is treated as a fresh IDLE beat and the FSM enters WAIT_A.
